gray_step_counter: RTL and testbench
====================================

// Module: gray_step_counter
// PURPOSE
//  Binary up/down counter with load and clear that registers its count and the
//  Gray encoding of that count (g = bin ^ (bin >> 1)) in the same cycle.
//  Sits directly upstream of the Gray converter stage. Supplies registered,
//  glitch-free Gray sequences to pointer, encoder and position-sensing logic.
//  Flags wrap events and any illegal multi-bit Gray step.
// PARAMETERS
//  N      4  counter / Gray width in bits (N >= 2)
// PORTS
//  clk       in   1  system clock, rising edge
//  rst       in   1  asynchronous, active-high reset
//  en        in   1  count enable; one step per cycle while high
//  up        in   1  direction: 1 = increment, 0 = decrement (sampled with en)
//  clr       in   1  synchronous clear to zero; also clears step_err
//  load      in   1  synchronous load of load_val
//  load_val  in   N  binary value to load
//  bin       out  N  registered binary count
//  g         out  N  registered Gray code of bin
//  wrap      out  1  one-cycle pulse on modular wrap during a count step
//  step_err  out  1  sticky diagnostic: Gray output made a non-unit step
// BEHAVIOUR
//  Clock and reset
//  - One clock (clk). Reset is asynchronous, active-high (rst).
//  - On rst: bin=0, g=0, wrap=0, step_err=0, immediately and independent of clk.
//  - Release of rst is synchronous to the first following rising clk edge.
//  Priority each cycle: clr > load > en > hold.
//  - clr: bin=0, g=0, wrap=0, step_err=0.
//  - load: bin=load_val, g=load_val^(load_val>>1), wrap=0.
//    A load is not a count step; step_err is not evaluated.
//  - en&up: bin = (bin+1) mod 2^N.
//  - en&~up: bin = (bin-1) mod 2^N.
//  - en=0: all registers hold; wrap=0.
//  Output timing
//  - g is computed from the next-state bin and registered alongside it.
//  - bin and g always update on the same edge, so g == bin^(bin>>1) holds in
//    every cycle (0-cycle skew, 1-cycle latency from inputs).
//  wrap
//  - Asserted for exactly the one cycle following a step from 2^N-1 to 0 (up)
//    or 0 to 2^N-1 (down).
//  - Deasserted in all other cycles, including clr or load to/from the extremes.
//  step_err
//  - Set on the cycle after a count step if popcount(g_new ^ g_old) != 1.
//  - Stays set until clr or rst. In correct RTL it never sets. It exists as a
//    guard for downstream consumers.
//  Boundary cases
//  - Direction reversal on consecutive cycles is legal and still a one-bit step.
//  - clr and load together: clr wins.
//  - rst asserted mid-count: outputs go to 0 asynchronously. Counting resumes
//    from 0 on the first enabled edge after rst deasserts.
//  - No combinational path from any input to any output.
// TESTING
//  T1 reset
//    rst=1 mid-count at bin=9 -> bin=0, g=0, wrap=0 before the next clk edge.
//  T2 up count
//    up=1, en=1 for 16 cycles from 0 ->
//    g = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then 0.
//    wrap=1 only in the cycle g returns to 0.
//  T3 down count
//    up=0, en=1 from 0 -> bin=F, g=8, wrap=1 for one cycle. Next: bin=E, g=9.
//  T4 load/clr
//    load=1, load_val=5 -> bin=5, g=7, wrap=0.
//    load=1 with clr=1 -> bin=0, g=0.
//  T5 reversal/hold
//    Alternate up/down each cycle at bin=7/8 -> g toggles 4<->C, step_err=0.
//    en=0 for 3 cycles -> outputs hold.
//  T6 random
//    10k cycles of random en/up/load/clr vs a reference model ->
//    g==bin^(bin>>1) every cycle, step_err never set.

Source files
------------

// File: rtl/gray_step_counter.sv
// gray_step_counter: binary up/down counter with clear and load. The Gray
// code of the count is registered on the same edge as the count, so the two
// outputs never skew. wrap pulses for one cycle after a modular wrap. step_err
// is a sticky flag that sets if a count step moves g by anything other than
// one bit.
//
// Interface timing: there is no valid/ready handshake. Every output is a
// register and is valid in every cycle. Inputs are sampled on the rising
// clk edge, and their effect appears on the outputs after that edge. No
// output has a combinational path from any input.
module gray_step_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] bin,
  output logic [N-1:0] g,
  output logic         wrap,
  output logic         step_err
);

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] MAXV = '1;

  logic [N-1:0] bin_q, bin_d;
  logic [N-1:0] g_q, g_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;

  function automatic logic [N-1:0] to_gray(input logic [N-1:0] v);
    return v ^ (v >> 1);
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic is_one_hot(input logic [N-1:0] v);
    return (v != ZERO) && ((v & (v - ONE)) == ZERO);
  endfunction

  // Next-state logic. Priority is clr > load > en > hold. g is derived from
  // the next binary value, so it is registered together with bin.
  always_comb begin
    bin_d  = bin_q;
    g_d    = g_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (clr) begin
      bin_d = ZERO;
      g_d   = ZERO;
      err_d = 1'b0;
    end else if (load) begin
      // A load is not a count step, so it is not checked for a unit Gray step.
      bin_d = load_val;
      g_d   = to_gray(load_val);
    end else if (en) begin
      if (up) begin
        bin_d  = bin_q + ONE;
        wrap_d = (bin_q == MAXV);
      end else begin
        bin_d  = bin_q - ONE;
        wrap_d = (bin_q == ZERO);
      end
      g_d = to_gray(bin_d);
      if (!is_one_hot(g_d ^ g_q)) begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= ZERO;
      g_q    <= ZERO;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bin      = bin_q;
  assign g        = g_q;
  assign wrap     = wrap_q;
  assign step_err = err_q;

endmodule

// File: tb/tb_gray_step_counter.sv
// Bench for gray_step_counter. The driver pushes the expected response for
// each cycle into a queue. A separate monitor pops one entry per clock and
// compares it with the DUT outputs.
module tb_gray_step_counter;

  localparam int N = 4;
  localparam int M = 1 << N;
  localparam int W = 2 * N + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] bin;
  logic [N-1:0] g;
  logic         wrap;
  logic         step_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state: the count as a plain integer.
  int m_cnt = 0;

  gray_step_counter #(.N(N)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .bin(bin), .g(g), .wrap(wrap), .step_err(step_err)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Packs the expected outputs for model count c.
  function automatic logic [W-1:0] pack_exp(input int c, input logic w);
    logic [N-1:0] b;
    b = N'(c);
    return {b, N'(c ^ (c / 2)), w, 1'b0};
  endfunction

  // Issues one cycle of stimulus, advances the model, and queues the expected outputs.
  task automatic drive_cycle(input logic e, input logic u, input logic c,
                             input logic l, input logic [N-1:0] lv);
    logic w;
    @(negedge clk);
    en = e; up = u; clr = c; load = l; load_val = lv;
    w = 1'b0;
    if (c) begin
      m_cnt = 0;
    end else if (l) begin
      m_cnt = int'(lv);
    end else if (e) begin
      if (u) begin
        w = (m_cnt + 1 >= M);
        m_cnt = (m_cnt + 1) % M;
      end else begin
        w = (m_cnt == 0);
        m_cnt = (m_cnt + M - 1) % M;
      end
    end
    exp_q.push_back(pack_exp(m_cnt, w));
  endtask

  task automatic idle_inputs();
    en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
  endtask

  // Compares the DUT outputs directly with an expected vector (used around reset).
  task automatic check_now(input string name, input logic [W-1:0] exp);
    logic [W-1:0] act;
    act = {bin, g, wrap, step_err};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got bin=%h g=%h wrap=%b err=%b, want bin=%h g=%h wrap=%b err=%b",
               name, act[W-1 -: N], act[N+1 -: N], act[1], act[0],
               exp[W-1 -: N], exp[N+1 -: N], exp[1], exp[0]);
    end
  endtask

  // Monitor: after every rising edge, pop and compare one expected entry.
  initial begin
    logic [W-1:0] exp;
    logic [W-1:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {bin, g, wrap, step_err};
        n_checks++;
        if (act !== exp) begin
          n_errors++;
          $display("FAIL cycle_check t=%0t: got bin=%h g=%h wrap=%b err=%b, want bin=%h g=%h wrap=%b err=%b",
                   $time, act[W-1 -: N], act[N+1 -: N], act[1], act[0],
                   exp[W-1 -: N], exp[N+1 -: N], exp[1], exp[0]);
        end
      end
    end
  end

  // Waits for the monitor to drain the queue. A timeout counts as a failure.
  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_drain: %0d entries left, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    // Reset is asserted at time zero, so the outputs must be zero before any edge.
    #3;
    check_now("reset_initial", '0);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0;

    // Count up to 9, then apply an asynchronous reset between edges.
    for (int i = 0; i < 9; i++) drive_cycle(1, 1, 0, 0, '0);
    drain("t1");
    check_now("pre_reset_bin9", pack_exp(9, 1'b0));
    idle_inputs();
    #1;
    rst = 1'b1;
    #1;
    check_now("async_reset", '0);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0;

    // Count up through a full wrap. The wrap pulse is covered by the model.
    for (int i = 0; i < 17; i++) drive_cycle(1, 1, 0, 0, '0);

    // Count down from zero, which wraps to all ones.
    drive_cycle(0, 0, 1, 0, '0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, 0, '0);

    // Load 5, then load and clear together (clear wins).
    drive_cycle(0, 0, 0, 1, 4'd5);
    drive_cycle(1, 1, 1, 1, 4'd9);

    // Loads to the extremes must not pulse wrap.
    drive_cycle(0, 0, 0, 1, 4'hF);
    drive_cycle(1, 1, 0, 0, '0);
    drive_cycle(0, 0, 0, 1, 4'h0);

    // Reverse direction every cycle around 7/8, then hold for three cycles.
    drive_cycle(0, 0, 0, 1, 4'd7);
    for (int i = 0; i < 6; i++) drive_cycle(1, (i % 2) == 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) drive_cycle(0, $urandom_range(0, 1), 0, 0, '0);
    drain("directed");

    // Apply random stimulus against the reference model.
    for (int i = 0; i < 10000; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                  N'($urandom_range(0, M - 1)));
    end
    drain("random");

    // Reset once more mid-count. Counting then resumes from zero.
    idle_inputs();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_now("async_reset_random", '0);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0;
    drive_cycle(1, 1, 0, 0, '0);
    drive_cycle(1, 1, 0, 0, '0);
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
